// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the response bundle returned to the command-side initiator.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: one command in flight, SETUP/ACCESS sequencing, PSLVERR
// propagation and a saturating wait-state watchdog that forces completion.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [CNT_W-1:0]      wait_q, wait_d, wait_inc;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  accept, timeout_hit;

  assign accept      = cmd_valid && cmd_ready;
  assign wait_inc    = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
  // wait_inc is the count including the current PREADY-low edge
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = PRESETn && (state_q == IDLE);
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    wait_d   = wait_q;
    rsp_d    = rsp_q;
    case (state_q)
      IDLE: if (accept) begin
        paddr_d  = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_write ? cmd_wdata : '0;
      end
      SETUP: wait_d = '0;
      ACCESS: begin
        if (PREADY) begin
          rsp_d.rdata   = pwrite_q ? '0 : APB_DATA_W'(PRDATA);
          rsp_d.err     = PSLVERR;
          rsp_d.timeout = 1'b0;
        end else begin
          wait_d = wait_inc;
          if (timeout_hit) begin
            rsp_d.rdata   = '0;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      wait_q   <= '0;
      rsp_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      wait_q   <= wait_d;
      rsp_q    <= rsp_d;
    end
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: doc/apb_master.md
# apb_master

Synthesizable APB requester that turns single request/response command handshakes into APB SETUP/ACCESS transfers on the peripheral bus. It sits between a system-side initiator (CPU bridge, DMA, test sequencer) and one or more APB completers. It handles wait states, propagates PSLVERR, and guards against hung completers with a wait-state watchdog. One transfer is outstanding at a time.

## Interface
- ADDR_WIDTH, 32, PADDR / cmd_addr width
- DATA_WIDTH, 32, PWDATA / PRDATA / cmd_wdata / rsp_rdata width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before forced termination; 0 disables the watchdog
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; high only in IDLE while PRESETn is high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accept
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled at completion, or watchdog timeout
- rsp_timeout  out  1  response was produced by the watchdog
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH  APB address/data
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1  APB completer return

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On an edge with cmd_valid&&cmd_ready: register addr/write/wdata onto PADDR/PWRITE/PWDATA (PWDATA=0 for reads), PSEL=1, PENABLE=0, go to SETUP.
- SETUP: always lasts exactly one cycle. Next edge: PENABLE=1, clear wait counter, go to ACCESS.
- ACCESS: each edge samples PREADY.
  - PREADY=1: PSEL=PENABLE=0; rsp_rdata=PRDATA for reads, 0 for writes; rsp_err=PSLVERR; rsp_timeout=0; go to RESP.
  - PREADY=0: counter++. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: PSEL=PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
- RESP: rsp_valid=1. On an edge with rsp_ready: rsp_valid=0, go to IDLE. The response fields are held stable until accepted.
- PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS and hold their last values while idle. They never change while PSEL=1.
- PRDATA and PSLVERR are sampled only on the completing ACCESS edge.
- Watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturating.

## Timing
- Reset (asynchronous, immediate): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout are all 0. cmd_ready=0 while PRESETn is low.
- Accept at edge 0 → PSEL=1 after edge 0 → PENABLE=1 after edge 1 → with PREADY=1 at edge 2, rsp_valid=1 after edge 2.
- Zero-wait latency is 3 edges from accept to rsp_valid. Each PREADY-low cycle adds 1.
- Throughput: the earliest next accept is the edge after rsp handshake, so the minimum period is 4 cycles per transfer with rsp_ready tied high.
- rsp_ready low stalls in RESP indefinitely. The bus is idle (PSEL=0) during the stall.
- Reset mid-transfer: PSEL/PENABLE drop immediately. The in-flight command is discarded and no response is produced.
- cmd_valid during a busy state is ignored (cmd_ready=0). The initiator must hold the command.

## Structure
- Shared package apb_pkg holds:
  - the apb_state_e enum (IDLE/SETUP/ACCESS/RESP)
  - default ADDR/DATA width constants
  - an apb_rsp_t struct {rdata, err, timeout}
- No sub-module. The FSM, capture registers and watchdog counter are all inline.

## Test plan
- Write 0xDEAD_BEEF to 0x10, then read 0x10, zero-wait completer → PSEL/PENABLE sequence is correct; rsp_rdata=0xDEAD_BEEF; rsp_err=0; 3-edge latency on each.
- Completer holds PREADY low for 3 ACCESS cycles on a read of 0x20 returning 0x1234 → PADDR is stable for all 5 PSEL cycles; rsp_valid arrives 6 edges after accept.
- Write to 0x30 with PSLVERR=1 at completion → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- PREADY stuck low with TIMEOUT_CYCLES=16 → PSEL drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; the next command completes normally.
- rsp_ready held low for 10 cycles after completion → rsp fields are stable, cmd_ready=0, PSEL=0; accept occurs on the first rsp_ready edge.
- PRESETn asserted during ACCESS → all outputs are 0 immediately; no rsp_valid; the first command after reset release completes normally.
